// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// Signal names are written from the fetch unit's point of view.
interface ifu_fetch_if;
   logic        imem_req_o;
   logic [63:0] imem_addr_o;
   logic        imem_ready_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ready_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ready_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit feeding the IF/ID register.
// Handles stalls, redirects and responses owed to a redirected-away access.
module ifu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              redirect_valid_i,
   input  logic [63:0]       redirect_pc_i,
   ifu_fetch_if.master       imem,
   output logic [63:0]       if_pc_o,
   output logic [31:0]       if_inst_o,
   output logic              if_valid_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [63:0] r_pc;
   logic [63:0] w_nextPc;
   logic        r_drop;
   logic        w_nextDrop;
   logic [63:0] r_ifPc;
   logic [63:0] w_nextIfPc;
   logic [31:0] r_ifInst;
   logic [31:0] w_nextIfInst;
   logic        r_ifValid;
   logic        w_nextIfValid;

   logic [63:0] w_redirPc;
   logic        w_accept;

   assign w_redirPc = redirect_pc_i & ~64'h3;

   // No request while a stale response is still owed to us.
   assign imem.imem_req_o  = (r_state == S_REQ) && !r_drop;
   assign imem.imem_addr_o = r_pc & ~64'h3;
   assign w_accept         = imem.imem_req_o && imem.imem_ready_i;

   assign if_pc_o    = r_ifPc;
   assign if_inst_o  = r_ifInst;
   assign if_valid_o = r_ifValid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_drop    <= 1'b0;
         r_ifPc    <= 64'd0;
         r_ifInst  <= NOP_INST;
         r_ifValid <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_pc      <= w_nextPc;
         r_drop    <= w_nextDrop;
         r_ifPc    <= w_nextIfPc;
         r_ifInst  <= w_nextIfInst;
         r_ifValid <= w_nextIfValid;
      end
   end

   always_comb begin
      w_nextState   = r_state;
      w_nextPc      = r_pc;
      w_nextDrop    = r_drop;
      w_nextIfPc    = r_ifPc;
      w_nextIfInst  = r_ifInst;
      w_nextIfValid = r_ifValid;

      // The owed response may land in any state; it only retires the drop flag.
      if (r_drop && imem.imem_rvalid_i) begin
         w_nextDrop = 1'b0;
      end

      case (r_state)
         S_IDLE: begin
            w_nextState = S_REQ;
            if (redirect_valid_i) begin
               w_nextPc = w_redirPc;
            end
         end

         S_REQ: begin
            if (redirect_valid_i) begin
               w_nextPc = w_redirPc;
               if (w_accept) begin
                  w_nextDrop = 1'b1;
               end
            end else if (w_accept) begin
               w_nextState = S_WAIT;
            end
         end

         S_WAIT: begin
            if (redirect_valid_i) begin
               w_nextPc    = w_redirPc;
               w_nextDrop  = !imem.imem_rvalid_i;
               w_nextState = S_REQ;
            end else if (imem.imem_rvalid_i) begin
               w_nextIfPc    = r_pc;
               w_nextIfInst  = imem.imem_rdata_i;
               w_nextIfValid = 1'b1;
               w_nextState   = S_OUT;
            end
         end

         S_OUT: begin
            if (redirect_valid_i) begin
               w_nextPc      = w_redirPc;
               w_nextIfValid = 1'b0;
               w_nextIfInst  = NOP_INST;
               w_nextState   = S_REQ;
            end else if (!stall_i) begin
               w_nextPc      = r_pc + 64'd4;
               w_nextIfValid = 1'b0;
               w_nextIfInst  = NOP_INST;
               w_nextState   = S_REQ;
            end
         end

         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch: boot, stall, redirects, PC wrap and
// asynchronous reset in the middle of an access.
module tb_ifu_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_valid_i;
   logic [63:0] redirect_pc_i;
   logic [63:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;

   int nAsserts = 0;
   int nFails   = 0;

   ifu_fetch_if bus ();

   ifu_fetch dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall_i          (stall_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem             (bus.master),
      .if_pc_o          (if_pc_o),
      .if_inst_o        (if_inst_o),
      .if_valid_o       (if_valid_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic stall, input logic redirV, input logic [63:0] redirPc,
                                input logic ready, input logic rvalid, input logic [31:0] rdata);
      stall_i           = stall;
      redirect_valid_i  = redirV;
      redirect_pc_i     = redirPc;
      bus.imem_ready_i  = ready;
      bus.imem_rvalid_i = rvalid;
      bus.imem_rdata_i  = rdata;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkFetch(input string tag, input logic valid, input logic [63:0] pc, input logic [31:0] inst);
      checkOutput({tag, "_valid"}, {63'd0, if_valid_o}, {63'd0, valid});
      checkOutput({tag, "_pc"}, if_pc_o, pc);
      checkOutput({tag, "_inst"}, {32'd0, if_inst_o}, {32'd0, inst});
   endtask

   task automatic checkReq(input string tag, input logic req, input logic [63:0] addr);
      checkOutput({tag, "_req"}, {63'd0, bus.imem_req_o}, {63'd0, req});
      if (req) checkOutput({tag, "_addr"}, bus.imem_addr_o, addr);
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0);
      #12;
      checkReq("reset", 1'b0, 64'd0);
      checkFetch("reset", 1'b0, 64'd0, NOP);

      // Boot
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
      tick();
      checkReq("boot_req", 1'b1, 64'h8000_0000);
      tick();
      checkReq("boot_wait", 1'b0, 64'd0);
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 32'h0010_0093);
      tick();
      checkFetch("boot_out", 1'b1, 64'h8000_0000, 32'h0010_0093);
      checkReq("boot_out", 1'b0, 64'd0);
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
      tick();
      checkFetch("boot_consume", 1'b0, 64'h8000_0000, NOP);
      checkReq("boot_next", 1'b1, 64'h8000_0004);

      // Stall three cycles in OUT
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 32'h0020_0113);
      tick();
      checkFetch("stall_out", 1'b1, 64'h8000_0004, 32'h0020_0113);
      applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkFetch("stall_hold", 1'b1, 64'h8000_0004, 32'h0020_0113);
         checkReq("stall_noreq", 1'b0, 64'd0);
      end
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
      tick();
      checkFetch("stall_consume", 1'b0, 64'h8000_0004, NOP);
      checkReq("stall_next", 1'b1, 64'h8000_0008);

      // Redirect while waiting; the owed response must be dropped
      tick();
      checkReq("rw_wait", 1'b0, 64'd0);
      applyStimulus(1'b0, 1'b1, 64'h8000_0102, 1'b1, 1'b0, 32'd0);
      tick();
      checkReq("rw_owed", 1'b0, 64'd0);
      checkFetch("rw_owed", 1'b0, 64'h8000_0004, NOP);
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      tick();
      checkFetch("rw_dropped", 1'b0, 64'h8000_0004, NOP);
      checkReq("rw_next", 1'b1, 64'h8000_0100);

      // Redirect in OUT while stalled
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 32'h0030_0193);
      tick();
      checkFetch("ro_out", 1'b1, 64'h8000_0100, 32'h0030_0193);
      applyStimulus(1'b1, 1'b1, 64'h9000_0000, 1'b1, 1'b0, 32'd0);
      tick();
      checkFetch("ro_drop", 1'b0, 64'h8000_0100, NOP);
      checkReq("ro_next", 1'b1, 64'h9000_0000);

      // Unaccepted request withdrawn by redirect, then PC wrap on consume
      applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 32'd0);
      tick();
      checkReq("wrap_req", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 32'h0040_0213);
      tick();
      checkFetch("wrap_out", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0040_0213);
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
      tick();
      checkReq("wrap_next", 1'b1, 64'h0);

      // Redirect coinciding with acceptance leaves a stale response owed
      applyStimulus(1'b0, 1'b1, 64'h8000_0200, 1'b1, 1'b0, 32'd0);
      tick();
      checkReq("rr_owed", 1'b0, 64'd0);
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 32'hBAD0_0BAD);
      tick();
      checkFetch("rr_dropped", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, NOP);
      checkReq("rr_next", 1'b1, 64'h8000_0200);

      // Asynchronous reset in WAIT
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
      tick();
      checkReq("mr_wait", 1'b0, 64'd0);
      rst_n = 1'b0;
      #2;
      checkFetch("mr_async", 1'b0, 64'd0, NOP);
      checkReq("mr_async", 1'b0, 64'd0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 32'hCAFE_F00D);
      tick();
      checkReq("mr_first", 1'b1, 64'h8000_0000);
      checkFetch("mr_late", 1'b0, 64'd0, NOP);
      tick();
      checkFetch("mr_late2", 1'b0, 64'd0, NOP);
      checkReq("mr_held", 1'b1, 64'h8000_0000);
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 32'h0050_0293);
      tick();
      checkFetch("mr_out", 1'b1, 64'h8000_0000, 32'h0050_0293);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
